button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the raw board push-buttons (the s/d/f/g keys: up, down, left, right) before they reach the VGA game logic. For each button it synchronises the input to `clk`, debounces it, and produces a clean level. It also produces one-cycle press/release pulses and a press-plus-auto-repeat strobe. It sits between the board pins and the up/down/left/right inputs of the game core, so the core sees exactly one event per physical press, plus paced repeats while a key is held.

## Interface
- `N_BTN`, default 4: number of independent button channels; bit 0=up, 1=down, 2=left, 3=right.
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the synchronised input must hold a new value before it is accepted (20 ms at 50 MHz); must be ≥1.
- `REPEAT_DELAY`, default 25_000_000: cycles from a press pulse to the first repeat pulse (500 ms); 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat pulses (100 ms); must be ≥1.
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: asynchronous, active-low reset.
- `btn_in` input N_BTN: raw button levels, active-high, asynchronous to `clk`.
- `btn_level` output N_BTN: debounced button state, 1 = held.
- `btn_press` output N_BTN: one-cycle pulse on an accepted 0→1 transition.
- `btn_release` output N_BTN: one-cycle pulse on an accepted 1→0 transition.
- `btn_strobe` output N_BTN: `btn_press` OR the auto-repeat pulse; this is the intended input to the game core.

## Operation
- Channels are fully independent, with no shared state. Simultaneous activity on any subset of channels behaves exactly as each channel would alone.
- Per channel:
  - Synchroniser: two-flop chain `s1 <= btn_in`, `s2 <= s1`.
  - Debounce:
    - counter `dcnt`, width $clog2(DEBOUNCE_CYCLES)+1.
    - If `s2 == btn_level`: `dcnt <= 0`.
    - Else if `dcnt == DEBOUNCE_CYCLES-1`: `btn_level <= s2`, `dcnt <= 0`.
    - Else: `dcnt <= dcnt+1`.
    - A glitch shorter than DEBOUNCE_CYCLES clears the count and never changes `btn_level`.
  - Edge pulses are registered. On the edge where `btn_level` updates 0→1, `btn_press <= 1`; on a 1→0 update, `btn_release <= 1`. All other edges: 0. Each pulse is high exactly one cycle, in the same cycle `btn_level` shows its new value.
  - Auto-repeat, a state machine per channel with states IDLE, DELAY, REPEAT:
    - IDLE: on an accepted press → DELAY, `rcnt <= 0`. Stays IDLE when REPEAT_DELAY==0.
    - DELAY: `rcnt` increments each cycle. When `rcnt == REPEAT_DELAY-1`: repeat pulse, `rcnt <= 0`, → REPEAT.
    - REPEAT: `rcnt` increments each cycle. When `rcnt == REPEAT_PERIOD-1`: repeat pulse, `rcnt <= 0`.
    - From DELAY or REPEAT, on an accepted release → IDLE, `rcnt <= 0`, and no repeat pulse on that edge. This holds even if the counter would have hit terminal count on the same edge.
    - `rcnt` width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD))+1.
  - `btn_strobe` is registered and equals press | repeat pulse.
- Reset (async assert, any time, including mid-debounce or mid-repeat): all flops, counters and outputs go to 0 and all FSMs to IDLE. A button still held when reset releases is treated as a new press after the full debounce latency.

## Timing
- Reset values: `btn_level`, `btn_press`, `btn_release`, `btn_strobe` all 0.
- Latency: `btn_in` is stable before clock edge E0. `s2` reflects it after edge E1. `btn_level`/`btn_press` update on edge E1+DEBOUNCE_CYCLES. Total: DEBOUNCE_CYCLES+2 edges from the first sampling edge E0.
- First repeat pulse: exactly REPEAT_DELAY cycles after the `btn_press` cycle. Subsequent pulses: every REPEAT_PERIOD cycles.
- No combinational path from `btn_in` to any output.

## Test plan
- Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated otherwise.
- Reset: hold `reset`=0 with `btn_in`=4'hF, then release `reset`. All outputs are 0 during reset. `btn_level`=4'hF and `btn_press`=4'hF for one cycle occur 6 edges after the reset release.
- Glitch rejection: a 3-cycle high pulse on `btn_in[0]` gives no change on any output. A 6-cycle high pulse gives `btn_press[0]` once, then `btn_release[0]` once, 6 cycles apart.
- Auto-repeat: hold `btn_in[2]` for 30 cycles after the press. `btn_strobe[2]` pulses at press+0, +10, +13, +16, …, +28. There is exactly one `btn_release[2]` and no strobe after release.
- Release on terminal count: time the accepted release to coincide with `rcnt==REPEAT_PERIOD-1`. There is no strobe on that edge and the FSM returns to IDLE.
- Simultaneous: press bits 1 and 3 on the same cycle and release only bit 3 later. Pulses on the two channels are identical until the release, and channel 1 keeps repeating.
- REPEAT_DELAY=0: a 50-cycle hold gives exactly one `btn_strobe` (the press).

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
// Conditions raw push-buttons for the game core. Each channel is synchronised,
// debounced, and turned into clean level, press/release pulses and a
// press-plus-auto-repeat strobe.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   btn_in       raw button levels, active-high, asynchronous to clk
//   btn_level    debounced button state (1 = held)
//   btn_press    one-cycle pulse on an accepted 0->1 transition
//   btn_release  one-cycle pulse on an accepted 1->0 transition
//   btn_strobe   press pulse OR auto-repeat pulse
module button_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_strobe
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX) + 1;

    localparam logic [DW-1:0] D_TC  = DW'(DEBOUNCE_CYCLES - 1);
    // Delay of 0 disables auto-repeat; the DELAY state is then unreachable.
    localparam logic [RW-1:0] RD_TC = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_TC = RW'(REPEAT_PERIOD - 1);
    localparam logic          RPT_EN = (REPEAT_DELAY != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_e;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          strobe_q;
        logic [DW-1:0] dcnt;
        logic [RW-1:0] rcnt;
        rpt_state_e    state;
        logic          accept_c;
        logic          acc_press_c;
        logic          acc_rel_c;

        // Debounced transition accepted on this edge.
        always_comb begin
            accept_c    = (s2 != level_q) && (dcnt == D_TC);
            acc_press_c = accept_c & s2;
            acc_rel_c   = accept_c & ~s2;
        end

        // Synchroniser, debounce counter and registered edge pulses.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1        <= 1'b0;
                s2        <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                dcnt      <= '0;
            end else begin
                s1        <= btn_in[i];
                s2        <= s1;
                press_q   <= acc_press_c;
                release_q <= acc_rel_c;
                if (s2 == level_q) begin
                    dcnt <= '0;
                end else if (dcnt == D_TC) begin
                    level_q <= s2;
                    dcnt    <= '0;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end
        end

        // Auto-repeat FSM; a release wins over a same-edge terminal count.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= ST_IDLE;
                rcnt     <= '0;
                strobe_q <= 1'b0;
            end else begin
                strobe_q <= acc_press_c;
                case (state)
                    ST_IDLE: begin
                        rcnt <= '0;
                        if (acc_press_c && RPT_EN) begin
                            state <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (acc_rel_c) begin
                            state <= ST_IDLE;
                            rcnt  <= '0;
                        end else if (rcnt == RD_TC) begin
                            strobe_q <= 1'b1;
                            rcnt     <= '0;
                            state    <= ST_REPEAT;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    ST_REPEAT: begin
                        if (acc_rel_c) begin
                            state <= ST_IDLE;
                            rcnt  <= '0;
                        end else if (rcnt == RP_TC) begin
                            strobe_q <= 1'b1;
                            rcnt     <= '0;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        rcnt  <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_strobe[i]  = strobe_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3 on the main instance, plus a REPEAT_DELAY=0 instance.
// Step index k counts rising edges after the input change; with these
// parameters an accepted press or release shows on step 6.
module tb_button_conditioner;

    localparam int DC = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int NEVER = 100000;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic [3:0] btn_level, btn_press, btn_release, btn_strobe;
    logic [3:0] btn_in2;
    logic [3:0] lvl2, prs2, rel2, stb2;

    int n_checks = 0;
    int n_fail   = 0;

    button_conditioner #(
        .N_BTN(4), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_strobe(btn_strobe)
    );

    button_conditioner #(
        .N_BTN(4), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)
    ) dut_norpt (
        .clk(clk), .reset(reset), .btn_in(btn_in2),
        .btn_level(lvl2), .btn_press(prs2),
        .btn_release(rel2), .btn_strobe(stb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected strobe: press at p, accepted release at r, repeat after rd then every RP.
    function automatic bit exp_strobe(input int k, input int p, input int r, input int rd);
        int d;
        if (k == p) return 1'b1;
        if (rd == 0 || k <= p || k >= r) return 1'b0;
        d = k - p;
        if (d < rd) return 1'b0;
        return ((d - rd) % RP) == 0;
    endfunction

    task automatic test_reset();
        logic [15:0] got, exp;
        reset   = 1'b0;
        btn_in  = 4'hF;
        btn_in2 = 4'h0;
        step(); step(); step();
        got = {btn_level, btn_press, btn_release, btn_strobe};
        n_checks++;
        if (got !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hold got %h exp %h", got, 16'h0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {(k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0, (k == 6) ? 4'hF : 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got %h exp %h", k, got, exp);
            end
        end
        btn_in = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            step();
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {(k < 6) ? 4'hF : 4'h0, 4'h0, (k == 6) ? 4'hF : 4'h0, 4'h0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_drop k=%0d got %h exp %h", k, got, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] got, exp;
        btn_in = 4'h1;
        for (int k = 1; k <= 12; k++) begin
            step();
            got = {btn_level, btn_press, btn_release, btn_strobe};
            n_checks++;
            if (got !== 16'h0) begin
                n_fail++;
                $display("FAIL glitch3 k=%0d got %h exp %h", k, got, 16'h0);
            end
            if (k == 3) btn_in = 4'h0;
        end
        btn_in = 4'h1;
        for (int k = 1; k <= 16; k++) begin
            step();
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {3'b0, k >= 6 && k < 12, 3'b0, k == 6, 3'b0, k == 12, 3'b0, k == 6};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pulse6 k=%0d got %h exp %h", k, got, exp);
            end
            if (k == 6) btn_in = 4'h0;
        end
    endtask

    task automatic test_auto_repeat();
        logic [15:0] got, exp;
        int nrel = 0;
        btn_in = 4'h4;
        for (int k = 1; k <= 45; k++) begin
            step();
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {1'b0, k >= 6 && k < 35, 2'b0, 1'b0, k == 6, 2'b0,
                   1'b0, k == 35, 2'b0, 1'b0, exp_strobe(k, 6, 35, RD), 2'b0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL auto_repeat k=%0d got %h exp %h", k, got, exp);
            end
            if (btn_release[2]) nrel++;
            if (k == 29) btn_in = 4'h0;
        end
        n_checks++;
        if (nrel !== 1) begin
            n_fail++;
            $display("FAIL auto_repeat_release_count got %0d exp 1", nrel);
        end
    endtask

    task automatic test_release_tc();
        logic [15:0] got, exp;
        logic        s;
        // Release accepted at step 37 = press+31, the REPEAT terminal count.
        btn_in = 4'h1;
        for (int k = 1; k <= 64; k++) begin
            step();
            s   = exp_strobe(k, 6, 37, RD) | exp_strobe(k, 51, NEVER, RD);
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {3'b0, (k >= 6 && k < 37) || k >= 51, 3'b0, k == 6 || k == 51,
                   3'b0, k == 37, 3'b0, s};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL release_tc k=%0d got %h exp %h", k, got, exp);
            end
            if (k == 31) btn_in = 4'h0;
            if (k == 45) btn_in = 4'h1;
        end
        btn_in = 4'h0;
        for (int k = 1; k <= 10; k++) step();
        n_checks++;
        if (btn_level !== 4'h0) begin
            n_fail++;
            $display("FAIL release_tc_drain got %h exp %h", btn_level, 4'h0);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] got, exp;
        logic [3:0]  el, ep, er, es;
        btn_in = 4'hA;
        for (int k = 1; k <= 50; k++) begin
            step();
            el = 4'h0; ep = 4'h0; er = 4'h0; es = 4'h0;
            el[1] = k >= 6 && k < 46;
            el[3] = k >= 6 && k < 26;
            ep[1] = k == 6;
            ep[3] = k == 6;
            er[1] = k == 46;
            er[3] = k == 26;
            es[1] = exp_strobe(k, 6, 46, RD);
            es[3] = exp_strobe(k, 6, 26, RD);
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {el, ep, er, es};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL simultaneous k=%0d got %h exp %h", k, got, exp);
            end
            if (k == 20) btn_in = 4'h2;
            if (k == 40) btn_in = 4'h0;
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic [15:0] got, exp;
        btn_in = 4'h1;
        for (int k = 1; k <= 20; k++) step();
        n_checks++;
        if (btn_level !== 4'h1) begin
            n_fail++;
            $display("FAIL mid_repeat_level got %h exp %h", btn_level, 4'h1);
        end
        reset = 1'b0;
        #1;
        got = {btn_level, btn_press, btn_release, btn_strobe};
        n_checks++;
        if (got !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset got %h exp %h", got, 16'h0);
        end
        step(); step();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            got = {btn_level, btn_press, btn_release, btn_strobe};
            exp = {3'b0, k >= 6, 3'b0, k == 6, 4'h0, 3'b0, k == 6};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_repress k=%0d got %h exp %h", k, got, exp);
            end
        end
        btn_in = 4'h0;
        for (int k = 1; k <= 10; k++) step();
        n_checks++;
        if (btn_level !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_repress_drain got %h exp %h", btn_level, 4'h0);
        end
    endtask

    task automatic test_no_repeat();
        logic [15:0] got, exp;
        int nstb = 0;
        btn_in2 = 4'h1;
        for (int k = 1; k <= 60; k++) begin
            step();
            got = {lvl2, prs2, rel2, stb2};
            exp = {3'b0, k >= 6 && k < 56, 3'b0, k == 6, 3'b0, k == 56, 3'b0, k == 6};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL no_repeat k=%0d got %h exp %h", k, got, exp);
            end
            if (stb2[0]) nstb++;
            if (k == 50) btn_in2 = 4'h0;
        end
        n_checks++;
        if (nstb !== 1) begin
            n_fail++;
            $display("FAIL no_repeat_strobe_count got %0d exp 1", nstb);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn_in  = 4'h0;
        btn_in2 = 4'h0;
        test_reset();
        test_glitch();
        test_auto_repeat();
        test_release_tc();
        test_simultaneous();
        test_reset_mid_repeat();
        test_no_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
